// File: rtl/door_pkg.sv
// Shared definitions for the door plant model, its controller top level and bench.
// Optional feature macro: DOOR_OBSTACLE_EN (adds an obstacle input that stalls closing).
package door_pkg;

  // Default geometry, reused by the controller top level and the bench
  localparam int DOOR_TRAVEL_STEPS = 16;
  localparam int DOOR_STEP_DIV     = 4;
  localparam int DOOR_STALL_CYCLES = 8;

  // Motor command and end-stop sensor widths
  localparam int DOOR_MOTOR_W = 1;
  localparam int DOOR_SENSE_W = 1;

  // Door plant state; the plant itself uses 3-bit constants with the same encoding
  typedef enum logic [2:0] {
    DS_IDLE    = 3'd0,
    DS_MOV_UP  = 3'd1,
    DS_MOV_DN  = 3'd2,
    DS_BLOCKED = 3'd3,
    DS_FAULT   = 3'd4
  } door_state_e;

endpackage

// File: rtl/door_plant_model_if.sv
// Motor command / sensor bundle between the door controller (master) and the plant (slave).
// DOOR_OBSTACLE_EN adds an obstacle line driven from the controller/test side.
interface door_plant_model_if #(
  parameter int TRAVEL_STEPS = door_pkg::DOOR_TRAVEL_STEPS
);
  localparam int PW = $clog2(TRAVEL_STEPS + 1);

  logic          ml;
  logic          mr;
  logic          sense_up;
  logic          sense_down;
  logic [PW-1:0] position;
  logic          moving;
  logic          stall;
  logic          fault;
`ifdef DOOR_OBSTACLE_EN
  logic          obstacle;

  modport master (output ml, mr, obstacle,
                  input  sense_up, sense_down, position, moving, stall, fault);
  modport slave  (input  ml, mr, obstacle,
                  output sense_up, sense_down, position, moving, stall, fault);
`else
  modport master (output ml, mr,
                  input  sense_up, sense_down, position, moving, stall, fault);
  modport slave  (input  ml, mr,
                  output sense_up, sense_down, position, moving, stall, fault);
`endif

endinterface

// File: rtl/door_step_timer.sv
// Step prescaler and end-stop stall counter for the door plant.
// Prescaler wraps to zero on its terminal count; stall counter saturates.
module door_step_timer #(
  parameter int STEP_DIV     = 4,
  parameter int STALL_CYCLES = 8
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic i_presc_clr,
  input  logic i_presc_en,
  input  logic i_stall_clr,
  input  logic i_stall_en,
  output logic o_presc_term,
  output logic o_stall
);
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);

  logic [PW-1:0] r_presc;
  logic [SW-1:0] r_stall_cnt;

  assign o_presc_term = (r_presc == PRESC_LAST);
  assign o_stall      = (r_stall_cnt == STALL_MAX);

  // Prescaler: clear wins over enable; the terminal count is the step cycle
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n)              r_presc <= '0;
    else if (i_presc_clr)    r_presc <= '0;
    else if (i_presc_en)     r_presc <= o_presc_term ? '0 : r_presc + 1'b1;
  end

  // Stall counter: counts pushing cycles, holds once stall is reached
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n)                        r_stall_cnt <= '0;
    else if (i_stall_clr)              r_stall_cnt <= '0;
    else if (i_stall_en && !o_stall)   r_stall_cnt <= r_stall_cnt + 1'b1;
  end

endmodule

// File: rtl/door_plant_model.sv
// Door mechanism plant: turns motor commands ml (close) / mr (open) into a
// stepped position plus end-stop sensors, stall and fault flags.
// Optional feature macro: DOOR_OBSTACLE_EN (obstacle holds a closing door).
module door_plant_model
  import door_pkg::*;
#(
  parameter int TRAVEL_STEPS = DOOR_TRAVEL_STEPS,
  parameter int STEP_DIV     = DOOR_STEP_DIV,
  parameter int STALL_CYCLES = DOOR_STALL_CYCLES,
  parameter int INIT_OPEN    = 0
) (
  input  logic                clk2m,
  input  logic                rst_n,
  door_plant_model_if.slave   bus
);
  localparam int PW = $clog2(TRAVEL_STEPS + 1);
  localparam logic [PW-1:0] POS_MAX = PW'(TRAVEL_STEPS);
  localparam logic [PW-1:0] POS_RST = (INIT_OPEN != 0) ? POS_MAX : '0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MOV_UP  = 3'd1;
  localparam logic [2:0] ST_MOV_DN  = 3'd2;
  localparam logic [2:0] ST_BLOCKED = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  logic [2:0]    r_state;
  logic [PW-1:0] r_pos;

  logic [2:0] w_nstate;
  logic       w_up, w_dn, w_both, w_at_top, w_at_bot, w_obstacle;
  logic       w_presc_clr, w_presc_en, w_stall_clr, w_stall_en;
  logic       w_presc_term, w_stall, w_step_up, w_step_dn;

  assign w_up     = bus.mr & ~bus.ml;
  assign w_dn     = bus.ml & ~bus.mr;
  assign w_both   = bus.ml &  bus.mr;
  assign w_at_top = (r_pos == POS_MAX);
  assign w_at_bot = (r_pos == '0);
`ifdef DOOR_OBSTACLE_EN
  assign w_obstacle = bus.obstacle;
`else
  assign w_obstacle = 1'b0;
`endif

  door_step_timer #(
    .STEP_DIV     (STEP_DIV),
    .STALL_CYCLES (STALL_CYCLES)
  ) u_timer (
    .clk2m        (clk2m),
    .rst_n        (rst_n),
    .i_presc_clr  (w_presc_clr),
    .i_presc_en   (w_presc_en),
    .i_stall_clr  (w_stall_clr),
    .i_stall_en   (w_stall_en),
    .o_presc_term (w_presc_term),
    .o_stall      (w_stall)
  );

  // Next state and timer control. The sampling cycle that starts a move or a
  // push already counts, so the first step lands STEP_DIV cycles after drive.
  always_comb begin
    w_nstate    = r_state;
    w_presc_clr = 1'b0;
    w_presc_en  = 1'b0;
    w_stall_clr = 1'b0;
    w_stall_en  = 1'b0;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    if (r_state == ST_FAULT) begin
      w_presc_clr = 1'b1;
      w_stall_clr = 1'b1;
    end else if (w_both) begin
      w_nstate    = ST_FAULT;
      w_presc_clr = 1'b1;
      w_stall_clr = 1'b1;
    end else if (w_up) begin
      if (r_state == ST_MOV_DN) begin
        // reversal drops the partial step and rests for a cycle
        w_nstate    = ST_IDLE;
        w_presc_clr = 1'b1;
        w_stall_clr = 1'b1;
      end else if (w_at_top) begin
        w_nstate    = ST_BLOCKED;
        w_presc_clr = 1'b1;
        w_stall_en  = 1'b1;
      end else begin
        w_nstate    = ST_MOV_UP;
        w_presc_en  = 1'b1;
        w_stall_clr = 1'b1;
        w_step_up   = w_presc_term;
      end
    end else if (w_dn) begin
      if (r_state == ST_MOV_UP) begin
        w_nstate    = ST_IDLE;
        w_presc_clr = 1'b1;
        w_stall_clr = 1'b1;
      end else if (w_at_bot) begin
        w_nstate    = ST_BLOCKED;
        w_presc_clr = 1'b1;
        w_stall_en  = 1'b1;
      end else if (w_obstacle) begin
        // held closing: prescaler frozen, pushing counts toward stall
        w_nstate    = ST_MOV_DN;
        w_stall_en  = 1'b1;
      end else begin
        w_nstate    = ST_MOV_DN;
        w_presc_en  = 1'b1;
        w_stall_clr = 1'b1;
        w_step_dn   = w_presc_term;
      end
    end else begin
      w_nstate    = ST_IDLE;
      w_presc_clr = 1'b1;
      w_stall_clr = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nstate;
  end

  // Position: steps are only requested away from the stops, so no wrap
  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n)         r_pos <= POS_RST;
    else if (w_step_up) r_pos <= r_pos + 1'b1;
    else if (w_step_dn) r_pos <= r_pos - 1'b1;
  end

  assign bus.position   = r_pos;
  assign bus.sense_up   = w_at_top;
  assign bus.sense_down = w_at_bot;
  assign bus.moving     = (r_state == ST_MOV_UP) || (r_state == ST_MOV_DN);
  assign bus.stall      = w_stall;
  assign bus.fault      = (r_state == ST_FAULT);

endmodule

// File: tb/tb_door_plant_model.sv
// Bench for door_plant_model: directed test-plan steps followed by random
// drive segments, all outputs compared every cycle with a behavioural model.
module tb_door_plant_model;
  import door_pkg::*;

  localparam int TS = 16;
  localparam int SD = 4;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  door_plant_model_if #(.TRAVEL_STEPS(TS)) bus ();

  door_plant_model #(
    .TRAVEL_STEPS (TS),
    .STEP_DIV     (SD),
    .STALL_CYCLES (SC),
    .INIT_OPEN    (0)
  ) dut (
    .clk2m (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef DOOR_OBSTACLE_EN
  assign bus.obstacle = 1'b0;
`endif

  always #250 clk = ~clk;

  // Behavioural model: position, consecutive drive cycles in the current
  // move, consecutive cycles pushing an end stop, sticky fault, and the
  // direction actually moved last cycle (0 none, 1 up, 2 down).
  int m_pos, m_run, m_push, m_dir;
  bit m_fault;

  function automatic void model_reset();
    m_pos = 0; m_run = 0; m_push = 0; m_dir = 0; m_fault = 1'b0;
  endfunction

  function automatic void model_step(input bit l, input bit r);
    if (m_fault) begin
      m_dir = 0; m_run = 0; m_push = 0;
    end else if (l && r) begin
      m_fault = 1'b1; m_dir = 0; m_run = 0; m_push = 0;
    end else if (r || l) begin
      int want = r ? 1 : 2;
      bit at_stop = r ? (m_pos == TS) : (m_pos == 0);
      if (m_dir != 0 && m_dir != want) begin
        m_dir = 0; m_run = 0; m_push = 0;      // reversal: one idle cycle
      end else if (at_stop) begin
        m_dir = 0; m_run = 0;
        if (m_push < SC) m_push++;
      end else begin
        m_dir = want; m_push = 0; m_run++;
        if (m_run == SD) begin
          m_run = 0;
          m_pos = r ? m_pos + 1 : m_pos - 1;
        end
      end
    end else begin
      m_dir = 0; m_run = 0; m_push = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_cmp++;
    assert (obs === 32'(exp))
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".position"},   32'(bus.position),   m_pos);
    chk({tag, ".sense_up"},   32'(bus.sense_up),   int'(m_pos == TS));
    chk({tag, ".sense_down"}, 32'(bus.sense_down), int'(m_pos == 0));
    chk({tag, ".moving"},     32'(bus.moving),     int'(m_dir != 0));
    chk({tag, ".stall"},      32'(bus.stall),      int'(m_push >= SC));
    chk({tag, ".fault"},      32'(bus.fault),      int'(m_fault));
  endtask

  // One clock: drive, let the edge sample it, advance the model, compare
  task automatic cyc(input bit l, input bit r, input string tag);
    bus.ml = l; bus.mr = r;
    @(posedge clk);
    model_step(l, r);
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    bus.ml = 1'b0; bus.mr = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_all(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.ml = 1'b0; bus.mr = 1'b0;
    model_reset();
    #10;

    // reset, then idle
    do_reset("reset");
    chk("reset.position_const", 32'(bus.position), 0);
    chk("reset.sense_down_const", 32'(bus.sense_down), 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "idle");

    // full opening travel
    for (int i = 1; i <= 64; i++) begin
      cyc(1'b0, 1'b1, "open");
      if (i == 3) chk("open.pos_c3", 32'(bus.position), 0);
      if (i == 4) begin
        chk("open.pos_c4", 32'(bus.position), 1);
        chk("open.sdown_c4", 32'(bus.sense_down), 0);
      end
      if (i == 63) chk("open.sup_c63", 32'(bus.sense_up), 0);
    end
    chk("open.pos_c64", 32'(bus.position), TS);
    chk("open.sup_c64", 32'(bus.sense_up), 1);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, "rest");

    // full closing travel then a couple of cycles into the stop
    for (int i = 0; i < 66; i++) cyc(1'b1, 1'b0, "close");
    chk("close.pos", 32'(bus.position), 0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, "rest");

    // push against the bottom stop
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b0, "blocked");
      if (i == 7) chk("blocked.stall_c7", 32'(bus.stall), 0);
      if (i == 8) chk("blocked.stall_c8", 32'(bus.stall), 1);
    end
    chk("blocked.pos", 32'(bus.position), 0);
    cyc(1'b0, 1'b0, "release");
    chk("release.stall", 32'(bus.stall), 0);

    // partial step discarded on release
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, "burst1");
    cyc(1'b0, 1'b0, "gap");
    chk("partial.pos", 32'(bus.position), 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, "burst2");
      if (i == 3) chk("redrive.pos_c3", 32'(bus.position), 1);
    end
    chk("redrive.pos_c4", 32'(bus.position), 2);

    // onward to 5, then both motors together
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, "to5");
    chk("to5.pos", 32'(bus.position), 5);
    cyc(1'b1, 1'b1, "both");
    chk("fault.flag", 32'(bus.fault), 1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, "frozen");
    chk("fault.frozen", 32'(bus.position), 5);
    do_reset("fault_reset");
    chk("fault_reset.fault", 32'(bus.fault), 0);

    // random drive segments
    for (int s = 0; s < 90; s++) begin
      int k = $urandom_range(0, 19);
      if (m_fault || k == 0) begin
        do_reset("rnd_reset");
      end else if (k == 1) begin
        cyc(1'b1, 1'b1, "rnd_both");
      end else begin
        int d = $urandom_range(0, 2);
        int len = $urandom_range(1, 40);
        for (int i = 0; i < len; i++) cyc(d == 2, d == 1, "rnd");
      end
    end

    // reset in the middle of a move
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, "pre_midrst");
    bus.mr = 1'b1;
    @(posedge clk);
    #100;
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("midrst.position", 32'(bus.position), 0);
    chk("midrst.moving", 32'(bus.moving), 0);
    bus.mr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, "after_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
